regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_sb.sv | 120 ++++++++++++
 tb/tb_regfile_sb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, write port, scoreboard reserve and bulk-clear handshake.
interface regfile_sb_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
);
    logic [AW-1:0]    read_reg1;
    logic [AW-1:0]    read_reg2;
    logic [WIDTH-1:0] reg1_data;
    logic [WIDTH-1:0] reg2_data;
    logic             write;
    logic [AW-1:0]    write_reg;
    logic [WIDTH-1:0] write_data;
    logic             reserve;
    logic [AW-1:0]    reserve_reg;
    logic             busy1;
    logic             busy2;
    logic             clear;
    logic             ready;

    modport master (
        output read_reg1, read_reg2, write, write_reg, write_data,
               reserve, reserve_reg, clear,
        input  reg1_data, reg2_data, busy1, busy2, ready
    );

    modport slave (
        input  read_reg1, read_reg2, write, write_reg, write_data,
               reserve, reserve_reg, clear,
        output reg1_data, reg2_data, busy1, busy2, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write bypass, a per-register busy scoreboard
// and a sequential bulk clear that walks every register once.
module regfile_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [AW-1:0]    idx;

    logic idle;
    logic wr_en;
    logic rsv_en;
    logic clr_step;
    logic hit1;
    logic hit2;

    function automatic logic hard_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idle       = 1'b0;
        wr_en      = 1'b0;
        rsv_en     = 1'b0;
        clr_step   = 1'b0;
        case (state)
            IDLE: begin
                idle   = 1'b1;
                wr_en  = bus.write && !hard_zero(bus.write_reg);
                rsv_en = bus.reserve && !hard_zero(bus.reserve_reg);
                if (bus.clear) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr_step = 1'b1;
                if (&idx) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reserve is applied after the write so a same-cycle reserve leaves the register busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
            idx  <= '0;
        end else if (clr_step) begin
            mem[idx]  <= '0;
            busy[idx] <= 1'b0;
            idx       <= idx + 1'b1;
        end else begin
            if (wr_en) begin
                mem[bus.write_reg]  <= bus.write_data;
                busy[bus.write_reg] <= 1'b0;
            end
            if (rsv_en) begin
                busy[bus.reserve_reg] <= 1'b1;
            end
            if (idle && bus.clear) begin
                idx <= '0;
            end
        end
    end

    assign hit1 = idle && bus.write && (bus.write_reg == bus.read_reg1);
    assign hit2 = idle && bus.write && (bus.write_reg == bus.read_reg2);

    always_comb begin
        bus.reg1_data = mem[bus.read_reg1];
        if (hard_zero(bus.read_reg1)) begin
            bus.reg1_data = '0;
        end else if (hit1) begin
            bus.reg1_data = bus.write_data;
        end
    end

    always_comb begin
        bus.reg2_data = mem[bus.read_reg2];
        if (hard_zero(bus.read_reg2)) begin
            bus.reg2_data = '0;
        end else if (hit2) begin
            bus.reg2_data = bus.write_data;
        end
    end

    assign bus.busy1 = busy[bus.read_reg1] && !hit1 && !hard_zero(bus.read_reg1);
    assign bus.busy2 = busy[bus.read_reg2] && !hit2 && !hard_zero(bus.read_reg2);
    assign bus.ready = idle;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against an array-based model.
module tb_regfile_sb;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_sb_if #(.WIDTH(32), .AW(5)) bus ();

    regfile_sb #(
        .WIDTH(32),
        .AW(5),
        .ZERO_REG(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_idle;
    int          m_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_idle = 1'b1;
        m_left = 0;
    endtask

    function automatic logic [31:0] exp_data(input int a);
        if (a == 0) return '0;
        if (m_idle && bus.write && int'(bus.write_reg) == a) return bus.write_data;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input int a);
        if (a == 0) return '0;
        if (m_idle && bus.write && int'(bus.write_reg) == a) return '0;
        return {31'd0, m_busy[a]};
    endfunction

    task automatic model_edge();
        int w;
        int r;
        w = int'(bus.write_reg);
        r = int'(bus.reserve_reg);
        if (m_idle) begin
            if (bus.write && w != 0) begin
                m_mem[w]  = bus.write_data;
                m_busy[w] = 1'b0;
            end
            if (bus.reserve && r != 0) m_busy[r] = 1'b1;
            if (bus.clear) begin
                m_idle = 1'b0;
                m_left = 32;
            end
        end else begin
            m_mem[32 - m_left]  = '0;
            m_busy[32 - m_left] = 1'b0;
            m_left--;
            if (m_left == 0) m_idle = 1'b1;
        end
    endtask

    // Inputs are set just after a rising edge; outputs are compared at the falling edge.
    task automatic cycle();
        @(negedge clk);
        check("rd1", bus.reg1_data, exp_data(int'(bus.read_reg1)));
        check("rd2", bus.reg2_data, exp_data(int'(bus.read_reg2)));
        check("busy1", {31'd0, bus.busy1}, exp_busy(int'(bus.read_reg1)));
        check("busy2", {31'd0, bus.busy2}, exp_busy(int'(bus.read_reg2)));
        check("ready", {31'd0, bus.ready}, {31'd0, m_idle});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        bus.write       = 1'b0;
        bus.write_reg   = '0;
        bus.write_data  = '0;
        bus.reserve     = 1'b0;
        bus.reserve_reg = '0;
        bus.clear       = 1'b0;
    endtask

    initial begin
        int lowcnt;
        total = 0;
        bad   = 0;
        quiet();
        bus.read_reg1 = '0;
        bus.read_reg2 = '0;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_busy1", {31'd0, bus.busy1}, 32'd0);
        check("rst_rd1", bus.reg1_data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Write r7 with bypass, then read it back on both ports.
        bus.write = 1'b1; bus.write_reg = 5'd7; bus.write_data = 32'hDEADBEEF;
        bus.read_reg1 = 5'd7; bus.read_reg2 = 5'd7;
        #1 check("r7_bypass", bus.reg1_data, 32'hDEADBEEF);
        cycle();
        quiet();
        #1 check("r7_rd1", bus.reg1_data, 32'hDEADBEEF);
        check("r7_rd2", bus.reg2_data, 32'hDEADBEEF);
        cycle();

        // Register 0 is hardwired.
        bus.write = 1'b1; bus.write_reg = 5'd0; bus.write_data = 32'h12345678;
        bus.reserve = 1'b1; bus.reserve_reg = 5'd0;
        bus.read_reg1 = 5'd0; bus.read_reg2 = 5'd0;
        cycle();
        quiet();
        #1 check("r0_data", bus.reg1_data, 32'd0);
        check("r0_busy", {31'd0, bus.busy1}, 32'd0);
        cycle();

        // Reserve r3, then write it.
        bus.reserve = 1'b1; bus.reserve_reg = 5'd3; bus.read_reg1 = 5'd3;
        cycle();
        quiet();
        #1 check("r3_busy_set", {31'd0, bus.busy1}, 32'd1);
        cycle();
        bus.write = 1'b1; bus.write_reg = 5'd3; bus.write_data = 32'h55;
        #1 check("r3_busy_wcycle", {31'd0, bus.busy1}, 32'd0);
        check("r3_data_wcycle", bus.reg1_data, 32'h55);
        cycle();
        quiet();
        #1 check("r3_busy_after", {31'd0, bus.busy1}, 32'd0);
        cycle();

        // Same-cycle reserve and write of r9.
        bus.write = 1'b1; bus.write_reg = 5'd9; bus.write_data = 32'hA5;
        bus.reserve = 1'b1; bus.reserve_reg = 5'd9; bus.read_reg1 = 5'd9;
        cycle();
        quiet();
        #1 check("r9_data", bus.reg1_data, 32'hA5);
        check("r9_busy", {31'd0, bus.busy1}, 32'd1);
        cycle();

        // Random traffic with occasional bulk clears.
        for (int n = 0; n < 400; n++) begin
            bus.write       = $urandom_range(0, 1) == 1;
            bus.write_reg   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.write_data  = $urandom;
            bus.reserve     = $urandom_range(0, 2) == 0;
            bus.reserve_reg = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.clear       = $urandom_range(0, 79) == 0;
            bus.read_reg1   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.read_reg2   = 5'($urandom);
            cycle();
        end
        quiet();
        while (!m_idle) cycle();

        // Fill everything (busy too), then bulk clear with a dropped write inside.
        for (int i = 1; i < 32; i++) begin
            bus.write = 1'b1; bus.write_reg = 5'(i); bus.write_data = $urandom | 32'h1;
            bus.reserve = 1'b1; bus.reserve_reg = 5'(i);
            bus.read_reg1 = 5'(i); bus.read_reg2 = 5'(32 - i);
            cycle();
        end
        quiet();
        bus.clear = 1'b1; bus.read_reg1 = 5'd5; bus.read_reg2 = 5'd31;
        cycle();
        quiet();
        lowcnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 3) begin
                bus.write = 1'b1; bus.write_reg = 5'd31; bus.write_data = 32'hBAD0BAD0;
            end else begin
                bus.write = 1'b0;
            end
            #3;
            if (bus.ready) break;
            lowcnt++;
            cycle();
        end
        quiet();
        check("clear_len", lowcnt, 32);
        for (int i = 0; i < 32; i++) begin
            bus.read_reg1 = 5'(i); bus.read_reg2 = 5'(31 - i);
            #1 check("post_clear_data", bus.reg1_data, 32'd0);
            check("post_clear_busy", {31'd0, bus.busy1}, 32'd0);
            cycle();
        end

        // Asynchronous reset in the middle of a clear.
        bus.write = 1'b1; bus.write_reg = 5'd20; bus.write_data = 32'hCAFEF00D;
        bus.read_reg1 = 5'd20; bus.read_reg2 = 5'd20;
        cycle();
        quiet();
        bus.clear = 1'b1;
        cycle();
        quiet();
        for (int k = 0; k < 10; k++) cycle();
        #1 check("pre_rst_r20", bus.reg1_data, 32'hCAFEF00D);
        #2 rst = 1'b0;
        #1 check("mid_rst_r20", bus.reg1_data, 32'd0);
        check("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
